logic_basic_ready_delay: RTL and testbench
==========================================

Name: logic_basic_ready_delay

Overview:
- Stream register slice that pipelines the backward (ready) path of the rx/tx valid/ready interface. The forward valid/data path is the job of the existing delay block.
- tx_tready is retimed through STAGES flops before it reaches rx_tready.
- An internal skid FIFO absorbs the beats still arriving while the delayed ready catches up.
- Used to break long tready timing paths between stream stages. No beat is ever dropped or duplicated.

Parameters:
WIDTH, 1, bits of rx_tdata/tx_tdata.
STAGES, 1, register stages on the ready path; 0 = full combinational pass-through.
(derived) DEPTH = 2*STAGES+2, skid FIFO entries; CW = $clog2(DEPTH+1), occupancy counter width.

Ports:
aclk  input  1  clock, all logic on rising edge.
areset_n  input  1  asynchronous active-low reset.
rx_tvalid  input  1  upstream beat valid.
rx_tdata  input  WIDTH  upstream beat data.
rx_tready  output  1  registered ready to upstream.
tx_tready  input  1  downstream ready.
tx_tvalid  output  1  beat valid to downstream.
tx_tdata  output  WIDTH  beat data to downstream.

Behaviour:
- Transfer rules:
  - Rx transfer when rx_tvalid && rx_tready.
  - Tx transfer when tx_tvalid && tx_tready.
  - Beats leave in acceptance order.
- STAGES==0:
  - rx_tready = tx_tready, tx_tvalid = rx_tvalid, tx_tdata = rx_tdata, all combinational.
  - No state. aclk/areset_n are unused.
- STAGES>0, FIFO:
  - DEPTH-entry circular buffer with wr_ptr and rd_ptr, each wrapping DEPTH-1 -> 0 (DEPTH need not be a power of 2).
  - Occupancy counter count, 0..DEPTH.
  - Write on rx transfer; read on tx transfer.
  - count_next = count + rx_xfer - tx_xfer; a simultaneous read and write leaves count unchanged.
- STAGES>0, outputs:
  - tx_tvalid = (count != 0).
  - tx_tdata = mem[rd_ptr].
  - No bypass: a beat accepted at edge N is first visible on tx at cycle N+1 (latency 1 when empty).
- STAGES>0, ready pipeline:
  - q_ready[0] <= (DEPTH - count_next) > STAGES.
  - q_ready[k] <= q_ready[k-1] for k = 1..STAGES-1.
  - rx_tready = q_ready[STAGES-1].
  - All ready flops update every cycle; no enable.
- Flow-control guarantee:
  - At most STAGES beats can be accepted after space drops to the threshold, so the FIFO never overflows.
  - Write while count==DEPTH is an assertion failure.
  - Read while count==0 is impossible, because tx_tvalid is 0.
- Throughput: with tx_tready held at 1, sustained 1 beat/cycle once the ready pipe has filled.
- Reset, asserted asynchronously:
  - count=0, wr_ptr=0, rd_ptr=0, all q_ready=0.
  - Therefore tx_tvalid=0 and rx_tready=0.
  - FIFO data storage is not reset.
- After reset release, rx_tready rises STAGES cycles later.
- Reset mid-operation: all buffered beats are discarded, and outputs go to their reset values immediately.
- rx_tdata is captured only on an rx transfer. tx_tdata while tx_tvalid=0 is don't-care.

Test Plan:
1. STAGES=2, WIDTH=8: release reset with tx_tready=1 -> rx_tready=0 on the first 2 edges after release, then 1. Drive 0x01..0x10 continuously -> tx shows 0x01..0x10 in order, one per cycle after the initial fill, no gaps.
2. STAGES=2: stream continuously, then drop tx_tready for 10 cycles -> rx_tready falls when count_next ≥ 4, seen 2 cycles later. count peaks ≤ 6, no overflow assertion. Raise tx_tready -> all beats drain in order, none lost.
3. STAGES=2: toggle tx_tready every cycle and rx_tvalid randomly for 1000 cycles -> scoreboard exact order match, count never exceeds 6.
4. STAGES=2: single beat 0xA5 into an empty FIFO with tx_tready=1 -> tx_tvalid=1 with 0xA5 exactly one cycle after acceptance, then tx_tvalid=0.
5. STAGES=0: tx_tready=0/1 and rx_tvalid=1 with rx_tdata=0x3C -> rx_tready mirrors tx_tready in the same cycle, and tx_tdata=0x3C combinationally.
6. STAGES=3: assert areset_n=0 mid-stream with 5 beats buffered -> tx_tvalid=0 and rx_tready=0 immediately. After release, first tx beat is the first post-reset rx beat.

Source files
------------

// File: rtl/logic_basic_ready_delay.sv
// Stream register slice: tready is retimed through STAGES flops and a
// small skid FIFO absorbs the beats still in flight while ready catches up.
module logic_basic_ready_delay #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 1
) (
   input  logic             aclk,
   input  logic             areset_n,
   input  logic             rx_tvalid,
   input  logic [WIDTH-1:0] rx_tdata,
   output logic             rx_tready,
   input  logic             tx_tready,
   output logic             tx_tvalid,
   output logic [WIDTH-1:0] tx_tdata
);

   generate
      if (STAGES == 0) begin : g_pass
         logic w_unused;

         assign w_unused  = aclk ^ areset_n;
         assign rx_tready = tx_tready;
         assign tx_tvalid = rx_tvalid;
         assign tx_tdata  = rx_tdata;
      end else begin : g_slice
         localparam int DEPTH = 2*STAGES + 2;
         localparam int CW    = $clog2(DEPTH + 1);
         localparam int PW    = $clog2(DEPTH);

         localparam logic [CW-1:0] LP_DEPTH  = CW'(DEPTH);
         localparam logic [CW-1:0] LP_STAGES = CW'(STAGES);
         localparam logic [PW-1:0] LP_LAST   = PW'(DEPTH - 1);

         logic [WIDTH-1:0]  r_mem [DEPTH];
         logic [PW-1:0]     r_wr_ptr;
         logic [PW-1:0]     r_rd_ptr;
         logic [CW-1:0]     r_count;
         logic [STAGES-1:0] r_ready;

         logic [CW-1:0]     w_count_next;
         logic              w_wr;
         logic              w_rd;
         logic              w_space;

         assign rx_tready = r_ready[STAGES-1];
         assign tx_tvalid = (r_count != '0);
         assign tx_tdata  = r_mem[r_rd_ptr];

         assign w_wr = rx_tvalid & rx_tready;
         assign w_rd = tx_tvalid & tx_tready;

         always_comb begin
            w_count_next = r_count;
            unique case ({w_wr, w_rd})
               2'b10:   w_count_next = r_count + 1'b1;
               2'b01:   w_count_next = r_count - 1'b1;
               default: w_count_next = r_count;
            endcase
         end

         // Keep room for the STAGES beats that can still arrive
         // before the retimed ready reaches upstream.
         assign w_space = (LP_DEPTH - w_count_next) > LP_STAGES;

         always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
               r_count  <= '0;
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_ready  <= '0;
            end else begin
               r_count <= w_count_next;
               if (w_wr)
                  r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
               if (w_rd)
                  r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
               r_ready[0] <= w_space;
               for (int k = 1; k < STAGES; k++)
                  r_ready[k] <= r_ready[k-1];
            end
         end

         always_ff @(posedge aclk) begin
            if (w_wr)
               r_mem[r_wr_ptr] <= rx_tdata;
         end

         a_no_overflow: assert property (
            @(posedge aclk) disable iff (!areset_n)
            !(w_wr && (r_count == LP_DEPTH)));

         a_no_underflow: assert property (
            @(posedge aclk) disable iff (!areset_n)
            !(w_rd && (r_count == '0)));
      end
   endgenerate

endmodule

// File: tb/tb_logic_basic_ready_delay.sv
// Directed bench for logic_basic_ready_delay: STAGES=2, 0 and 3
// instances with a queue scoreboard on the STAGES=2 slice.
module tb_logic_basic_ready_delay;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // STAGES=2 instance
   logic       rst2;
   logic       s2_rxv, s2_rxr, s2_txv, s2_txr;
   logic [7:0] s2_rxd, s2_txd;

   // STAGES=0 instance
   logic       s0_rxv, s0_rxr, s0_txv, s0_txr;
   logic [7:0] s0_rxd, s0_txd;

   // STAGES=3 instance
   logic       rst3;
   logic       s3_rxv, s3_rxr, s3_txv, s3_txr;
   logic [7:0] s3_rxd, s3_txd;

   logic_basic_ready_delay #(.WIDTH(8), .STAGES(2)) u_s2 (
      .aclk(clk), .areset_n(rst2),
      .rx_tvalid(s2_rxv), .rx_tdata(s2_rxd), .rx_tready(s2_rxr),
      .tx_tready(s2_txr), .tx_tvalid(s2_txv), .tx_tdata(s2_txd));

   logic_basic_ready_delay #(.WIDTH(8), .STAGES(0)) u_s0 (
      .aclk(clk), .areset_n(1'b1),
      .rx_tvalid(s0_rxv), .rx_tdata(s0_rxd), .rx_tready(s0_rxr),
      .tx_tready(s0_txr), .tx_tvalid(s0_txv), .tx_tdata(s0_txd));

   logic_basic_ready_delay #(.WIDTH(8), .STAGES(3)) u_s3 (
      .aclk(clk), .areset_n(rst3),
      .rx_tvalid(s3_rxv), .rx_tdata(s3_rxd), .rx_tready(s3_rxr),
      .tx_tready(s3_txr), .tx_tvalid(s3_txv), .tx_tdata(s3_txd));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [7:0] sb[$];
   logic       x_rx, x_tx;
   int         cyc, peak, n_out, first_tx, last_tx;

   // One cycle on the STAGES=2 slice: observe at negedge, return after posedge.
   task automatic step2();
      logic [7:0] e;
      @(negedge clk);
      x_tx = s2_txv && s2_txr;
      x_rx = s2_rxv && s2_rxr;
      if (x_tx) begin
         if (sb.size() == 0) begin
            chk("sb_spurious", 32'(s2_txd), 32'hFFFF);
         end else begin
            e = sb.pop_front();
            chk("sb_order", 32'(s2_txd), 32'(e));
         end
         if (n_out == 0) first_tx = cyc;
         last_tx = cyc;
         n_out++;
      end
      if (x_rx) sb.push_back(s2_rxd);
      if (sb.size() > peak) peak = sb.size();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      logic [7:0] d;
      int         acc, n_in;
      bit         got;
      logic [7:0] first;

      rst2 = 1'b0; rst3 = 1'b0;
      s2_rxv = 0; s2_rxd = 0; s2_txr = 0;
      s0_rxv = 0; s0_rxd = 0; s0_txr = 0;
      s3_rxv = 0; s3_rxd = 0; s3_txr = 0;
      cyc = 0; peak = 0; n_out = 0; first_tx = 0; last_tx = 0;

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_rxready", 32'(s2_rxr), 32'd0);
      chk("rst_txvalid", 32'(s2_txv), 32'd0);

      // 1: ready rise after reset, then 0x01..0x10 streamed with no gaps
      @(posedge clk); #1;
      s2_txr = 1'b1;
      rst2   = 1'b1;
      @(negedge clk);
      chk("t1_rdy_e0", 32'(s2_rxr), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_rdy_e1", 32'(s2_rxr), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_rdy_e2", 32'(s2_rxr), 32'd1);
      @(posedge clk); #1;

      d = 8'h01; s2_rxv = 1'b1; s2_rxd = d;
      for (int i = 0; i < 200 && s2_rxv; i++) begin
         step2();
         if (x_rx) begin
            if (d == 8'h10) s2_rxv = 1'b0;
            else begin d++; s2_rxd = d; end
         end
      end
      repeat (5) step2();
      chk("t1_count", 32'(n_out), 32'd16);
      chk("t1_nogap", 32'(last_tx - first_tx), 32'd15);

      // 2: stall downstream for 10 cycles while streaming
      d = 8'h20; s2_rxd = d; s2_rxv = 1'b1;
      repeat (6) begin
         step2();
         if (x_rx) begin d++; s2_rxd = d; end
      end
      chk("t2_occ_pre", 32'(sb.size()), 32'd1);
      peak = 0;
      s2_txr = 1'b0;
      repeat (10) begin
         step2();
         if (x_rx) begin d++; s2_rxd = d; end
      end
      chk("t2_rdy_low", 32'(s2_rxr), 32'd0);
      chk("t2_occ", 32'(sb.size()), 32'd5);
      chk("t2_peak", 32'(peak), 32'd5);
      chk("t2_peak_le6", 32'(peak <= 6), 32'd1);
      s2_rxv = 1'b0;
      s2_txr = 1'b1;
      repeat (10) step2();
      chk("t2_drained", 32'(sb.size()), 32'd0);
      chk("t2_txv_idle", 32'(s2_txv), 32'd0);

      // 3: toggling downstream ready and random upstream valid
      peak = 0; n_out = 0; n_in = 0;
      d = 8'h00; s2_rxd = d;
      for (int i = 0; i < 1000; i++) begin
         s2_txr = ~s2_txr;
         s2_rxv = 1'($urandom_range(0, 1));
         step2();
         if (x_rx) begin n_in++; d++; s2_rxd = d; end
      end
      s2_rxv = 1'b0;
      s2_txr = 1'b1;
      repeat (10) step2();
      chk("t3_drained", 32'(sb.size()), 32'd0);
      chk("t3_in_eq_out", 32'(n_out), 32'(n_in));
      chk("t3_traffic", 32'(n_in > 100), 32'd1);
      chk("t3_peak_le6", 32'(peak <= 6), 32'd1);

      // 4: single beat latency
      s2_rxd = 8'hA5; s2_rxv = 1'b1;
      @(negedge clk);
      chk("t4_rdy", 32'(s2_rxr), 32'd1);
      chk("t4_txv_pre", 32'(s2_txv), 32'd0);
      @(posedge clk); #1;
      s2_rxv = 1'b0;
      @(negedge clk);
      chk("t4_txv", 32'(s2_txv), 32'd1);
      chk("t4_txd", 32'(s2_txd), 32'hA5);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_txv_post", 32'(s2_txv), 32'd0);

      // 5: STAGES=0 pass-through
      s0_rxv = 1'b1; s0_rxd = 8'h3C; s0_txr = 1'b0;
      #1;
      chk("t5_rdy0", 32'(s0_rxr), 32'd0);
      chk("t5_txv", 32'(s0_txv), 32'd1);
      chk("t5_txd", 32'(s0_txd), 32'h3C);
      s0_txr = 1'b1;
      #1;
      chk("t5_rdy1", 32'(s0_rxr), 32'd1);
      s0_rxv = 1'b0;
      #1;
      chk("t5_txv0", 32'(s0_txv), 32'd0);

      // 6: STAGES=3 reset with 5 beats buffered
      @(posedge clk); #1;
      rst3 = 1'b1;
      s3_txr = 1'b0;
      d = 8'h40; s3_rxd = d; s3_rxv = 1'b1;
      acc = 0;
      for (int i = 0; i < 50 && s3_rxv; i++) begin
         @(negedge clk);
         got = s3_rxv && s3_rxr;
         @(posedge clk); #1;
         if (got) begin
            acc++;
            if (acc == 5) s3_rxv = 1'b0;
            else begin d++; s3_rxd = d; end
         end
      end
      chk("t6_accepted", 32'(acc), 32'd5);
      @(negedge clk);
      chk("t6_txv_pre", 32'(s3_txv), 32'd1);
      chk("t6_txd_pre", 32'(s3_txd), 32'h40);
      #2;
      rst3 = 1'b0;
      #1;
      chk("t6_rst_txv", 32'(s3_txv), 32'd0);
      chk("t6_rst_rdy", 32'(s3_rxr), 32'd0);
      @(posedge clk); #1;
      rst3 = 1'b1;
      s3_txr = 1'b1;
      d = 8'h90; s3_rxd = d; s3_rxv = 1'b1;
      got = 1'b0; first = 8'h00;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (s3_txv && s3_txr) begin
            got = 1'b1;
            first = s3_txd;
         end
         acc = (s3_rxv && s3_rxr) ? 1 : 0;
         @(posedge clk); #1;
         if (acc == 1) begin d++; s3_rxd = d; end
      end
      chk("t6_got_beat", 32'(got), 32'd1);
      chk("t6_first", 32'(first), 32'h90);
      s3_rxv = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
